imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit words.
- Drives the memory write port (address, data, write enable) to store those words.
- Holds the processor in reset (active-low CPU_RST_X) until the image is fully written, then releases it so fetch starts at PC 0.
- Replaces testbench hierarchical preloading of imem with a synthesizable load path.

Parameters:
- BASE_ADDR, 32'h0, byte address of the first word written (multiple of 4).
- MAX_WORDS, 8192, capacity in words; matches the 8K-word MEM.
- RELEASE_DLY, 4, cycles between DONE rising and CPU_RST_X rising (1..15).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- IN_VALID  input  1  byte present on IN_DATA.
- IN_DATA  input  8  program byte; first byte of each word goes to bits [31:24] (big-endian).
- IN_LAST  input  1  marks final byte of the image; qualified by IN_VALID.
- IN_READY  output  1  loader accepts the byte this cycle.
- MEM_ADDR  output  32  byte address to memory, word aligned.
- MEM_DIN  output  32  write data.
- MEM_WE  output  1  write strobe, one cycle per word.
- CPU_RST_X  output  1  active-low processor reset.
- DONE  output  1  image fully written.
- ERR  output  1  overflow or checksum failure; sticky until RST.
- WORD_CNT  output  14  words written so far.

Behaviour:
- Reset (asynchronous on RST high): state IDLE; all outputs 0 (CPU_RST_X=0, IN_READY=0, MEM_WE=0, MEM_ADDR=BASE_ADDR, MEM_DIN=0, WORD_CNT=0); byte index=0; shift register=0.
- Handshake: a byte transfers on a rising CLK edge when IN_VALID && IN_READY. IN_DATA/IN_LAST are sampled only then.
- States:
  - IDLE: one cycle after reset release, go to LOAD.
  - LOAD: IN_READY=1. Each accepted byte shifts into word[31:0] at position byte index (0 -> [31:24] ... 3 -> [7:0]), then byte index increments mod 4. On the 4th byte, or on IN_LAST, go to WRITE.
  - WRITE: IN_READY=0 for exactly one cycle; MEM_WE=1, MEM_DIN=packed word, MEM_ADDR=BASE_ADDR+4*WORD_CNT. WORD_CNT increments at the end of the cycle. Next state is LOAD, or RELEASE if the word closed on IN_LAST.
  - RELEASE: DONE=1, IN_READY=0; counts RELEASE_DLY cycles, then CPU_RST_X=1 and state HALT.
  - HALT: terminal; IN_READY=0; DONE=1; CPU_RST_X=1; only RST leaves it.
- Partial word: if IN_LAST arrives with byte index <3, the unfilled low bytes are 0 (e.g. bytes AA,BB,last -> 32'hAABB0000).
- Throughput: 4 bytes accepted in 4 cycles, plus 1 write cycle, so 5 cycles per word minimum. Latency from the 4th byte accepted to MEM_WE high is 1 cycle.
- Overflow: a byte accepted while WORD_CNT==MAX_WORDS is discarded with no write and sets ERR. IN_READY stays 1 to drain the stream; on IN_LAST go to RELEASE, but CPU_RST_X stays 0 whenever ERR=1.
- IN_VALID low in mid-word: state holds, partial word retained indefinitely.
- IN_LAST with IN_VALID low: ignored.
- RST mid-load: everything returns to reset values immediately. Words already written to memory are not erased; CPU_RST_X drops to 0 asynchronously.
- Empty image is not supported; the first IN_LAST byte is always data, except as modified under the Optional Feature.

Optional Feature:
- Macro LOADER_CKSUM_EN.
- Defined: the IN_LAST byte is a checksum, not data. The loader keeps a running 8-bit sum (mod 256) of all data bytes. On the checksum byte, any pending partial word is zero-padded and written (WRITE state), then the loader enters RELEASE.
  - Checksum byte == two's complement of the sum: normal release.
  - Otherwise: ERR=1 and CPU_RST_X stays 0.
  - A checksum byte arriving with no data accepted: nothing written, proceed to RELEASE.
- Not defined: no sum register; the IN_LAST byte is data as described in Behaviour.

Decomposition:
- Shared package loader_pkg: state encoding (IDLE, LOAD, WRITE, RELEASE, HALT), WORD_W=32, BYTE_W=8, and function cksum_ok(sum, byte).
- One natural sub-module, byte_packer: shift/position logic, byte index counter, and zero-padding. It outputs word and word_ready to the control FSM.

Test Plan:
- Stream 00 A5 08 20 | 00 00 00 00 (last on 8th byte) -> writes 32'h00A50820 @0x0 then 32'h0 @0x4. WORD_CNT=2, DONE=1, CPU_RST_X rises 4 cycles after DONE.
- Bytes 12,34,56 with IN_LAST on 56 -> single write 32'h12345600 @BASE_ADDR, ERR=0.
- IN_VALID toggled 1,0,0,1,1,0,1 across one word -> same 32'h word as a gap-free stream; MEM_WE pulses exactly once, one cycle after the 4th accepted byte.
- MAX_WORDS=2, stream 12 bytes -> only 2 writes, ERR=1, DONE=1, CPU_RST_X stays 0.
- RST asserted after 6 bytes -> all outputs 0 within the same cycle. A new 4-byte stream then writes @BASE_ADDR with WORD_CNT=1.
- LOADER_CKSUM_EN: bytes 01 02 03 04 + checksum F6 -> write 32'h01020304, ERR=0, CPU released. Same bytes with checksum F5 -> ERR=1, CPU_RST_X=0.

Source files
------------

// File: rtl/loader_pkg.sv
// ----------------------------------------------------------------------------
// loader_pkg
//   Shared definitions for the instruction-memory loader: FSM state
//   encoding, datapath widths and the checksum helper.
//
//   Optional feature macro: LOADER_CKSUM_EN (only cksum_ok is tied to it;
//   the package itself is identical in both builds).
// ----------------------------------------------------------------------------
package loader_pkg;

    localparam int WORD_W = 32;  // packed memory word
    localparam int BYTE_W = 8;   // stream element
    localparam int CNT_W  = 14;  // word counter, holds 0..8192 and beyond
    localparam int IDX_W  = 2;   // byte position inside a word
    localparam int DLY_W  = 4;   // release delay counter, 1..15

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        WRITE   = 3'd2,
        RELEASE = 3'd3,
        HALT    = 3'd4
    } state_t;

    // The image is good when the running byte sum plus the checksum byte
    // wraps to zero, i.e. the checksum is the two's complement of the sum.
    function automatic logic cksum_ok(input logic [BYTE_W-1:0] sum,
                                      input logic [BYTE_W-1:0] cbyte);
        logic [BYTE_W-1:0] total;
        total = sum + cbyte;
        return (total == '0);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer
//   Big-endian byte-to-word packer. The first byte of a word lands in
//   [31:24], the fourth in [7:0]. Bytes not yet received read as zero, so a
//   word closed early is already zero-padded.
//
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     push        accept data into the current byte position
//     last        this pushed byte closes the word regardless of position
//     data        byte to store
//     clear       empty the word and restart at position 0 (write cycle)
//     word        packed word, stable until clear
//     word_ready  the push happening this cycle completes the word
//     pending     at least one byte of an unwritten word is held
// ----------------------------------------------------------------------------
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              last,
    input  logic [BYTE_W-1:0] data,
    input  logic              clear,
    output logic [WORD_W-1:0] word,
    output logic              word_ready,
    output logic              pending
);

    logic [IDX_W-1:0] idx;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (push) begin
            case (idx)
                2'd0:    word[31:24] <= data;
                2'd1:    word[23:16] <= data;
                2'd2:    word[15:8]  <= data;
                default: word[7:0]   <= data;
            endcase
            // Wraps to 0 after the fourth byte; the write cycle clears anyway.
            idx <= idx + 1'b1;
        end
    end

    assign word_ready = push && ((idx == 2'd3) || last);
    assign pending    = (idx != '0);

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Receives a program image as a
//   byte stream (valid/ready), packs it into big-endian 32-bit words, writes
//   them to consecutive word addresses from BASE_ADDR, and keeps the CPU in
//   reset until the image is complete plus RELEASE_DLY cycles.
//
//   Optional feature macro: LOADER_CKSUM_EN
//     defined   : the IN_LAST byte is a checksum over all data bytes; a bad
//                 checksum sets ERR and keeps the CPU in reset.
//     undefined : the IN_LAST byte is ordinary data.
//
//   Parameters:
//     BASE_ADDR    byte address of the first word (multiple of 4)
//     MAX_WORDS    capacity in words; further data bytes are dropped + ERR
//     RELEASE_DLY  cycles from DONE rising to CPU_RST_X rising (1..15)
//
//   Ports:
//     CLK, RST      clock, asynchronous active-high reset
//     IN_VALID      byte present on IN_DATA
//     IN_DATA       program byte
//     IN_LAST       final byte of the image (qualified by IN_VALID)
//     IN_READY      loader accepts a byte this cycle
//     MEM_ADDR      word-aligned byte address of the write port
//     MEM_DIN       write data (zero outside the write cycle)
//     MEM_WE        one-cycle write strobe per word
//     CPU_RST_X     active-low processor reset
//     DONE          image fully written
//     ERR           overflow or checksum failure, sticky until RST
//     WORD_CNT      words written so far
// ----------------------------------------------------------------------------
module imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          MAX_WORDS   = 8192,
    parameter int          RELEASE_DLY = 4
)(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic [BYTE_W-1:0]    IN_DATA,
    input  logic                 IN_LAST,
    output logic                 IN_READY,
    output logic [WORD_W-1:0]    MEM_ADDR,
    output logic [WORD_W-1:0]    MEM_DIN,
    output logic                 MEM_WE,
    output logic                 CPU_RST_X,
    output logic                 DONE,
    output logic                 ERR,
    output logic [CNT_W-1:0]     WORD_CNT
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_WORDS);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(RELEASE_DLY - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  word_cnt;
    logic [DLY_W-1:0]  rel_cnt;
    logic              err;
    logic              close_last;   // word in WRITE was closed by IN_LAST
    logic              cpu_run;

    logic              accept;
    logic              overflow;
    logic              final_byte;
    logic              data_byte;    // accepted byte that goes into memory
    logic              packer_last;
    logic              err_set;
    logic              rel_done;

    logic [WORD_W-1:0] word;
    logic              word_ready;

    assign accept     = IN_VALID && IN_READY;
    assign overflow   = (word_cnt == MAX_CNT);
    assign final_byte = accept && IN_LAST;
    assign rel_done   = (rel_cnt == DLY_LAST);

`ifdef LOADER_CKSUM_EN
    logic [BYTE_W-1:0] sum;
    logic              pending;

    // The closing byte is the checksum and never enters the packer.
    assign data_byte   = accept && !IN_LAST && !overflow;
    assign packer_last = 1'b0;
    assign err_set     = (accept && !IN_LAST && overflow) ||
                         (final_byte && !cksum_ok(sum, IN_DATA));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sum <= '0;
        end else if (data_byte) begin
            sum <= sum + IN_DATA;
        end
    end
`else
    assign data_byte   = accept && !overflow;
    assign packer_last = IN_LAST;
    assign err_set     = accept && overflow;
`endif

    byte_packer u_packer (
        .clk        (CLK),
        .rst        (RST),
        .push       (data_byte),
        .last       (packer_last),
        .data       (IN_DATA),
        .clear      (state == WRITE),
        .word       (word),
        .word_ready (word_ready),
`ifdef LOADER_CKSUM_EN
        .pending    (pending)
`else
        .pending    ()
`endif
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves
        // state_nxt unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: state_nxt = LOAD;
            LOAD: begin
                if (final_byte) begin
`ifdef LOADER_CKSUM_EN
                    // Flush a partial word before release; none -> no write.
                    state_nxt = pending ? WRITE : RELEASE;
`else
                    // On overflow the last byte was dropped: nothing to write.
                    state_nxt = word_ready ? WRITE : RELEASE;
`endif
                end else if (word_ready) begin
                    state_nxt = WRITE;
                end
            end
            WRITE:   state_nxt = close_last ? RELEASE : LOAD;
            RELEASE: if (rel_done) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        IN_READY = (state == LOAD);
        MEM_WE   = (state == WRITE);
        MEM_DIN  = (state == WRITE) ? word : '0;
        DONE     = (state == RELEASE) || (state == HALT);
    end

    assign MEM_ADDR  = BASE_ADDR + {{(WORD_W-CNT_W-2){1'b0}}, word_cnt, 2'b00};
    assign CPU_RST_X = cpu_run;
    assign ERR       = err;
    assign WORD_CNT  = word_cnt;

    // ------------------------------------------------------------- counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            word_cnt   <= '0;
            rel_cnt    <= '0;
            err        <= 1'b0;
            close_last <= 1'b0;
            cpu_run    <= 1'b0;
        end else begin
            if (state == WRITE) begin
                word_cnt <= word_cnt + 1'b1;
            end

            rel_cnt <= (state == RELEASE) ? rel_cnt + 1'b1 : '0;

            if (err_set) begin
                err <= 1'b1;
            end

            if (state == LOAD && accept) begin
                close_last <= IN_LAST;
            end

            // Registered so the processor reset never glitches; an image
            // with ERR set leaves the CPU in reset for good.
            if (state == RELEASE && rel_done) begin
                cpu_run <= !err;
            end
        end
    end

endmodule
